// File: rtl/fifo_stream_reader.sv
// Read-side consumer for async_fifo: pops words, absorbs the one-cycle read latency
// in a 3-entry prefetch buffer and presents a packet-framed valid/ready stream.
module fifo_stream_reader #(
    parameter int Width     = 8,
    parameter int PacketLen = 4,
    parameter int CntWidth  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_enable,
    output logic                o_rd_en,
    input  logic [Width-1:0]    i_rd_data,
    input  logic                i_empty,
    output logic                o_valid,
    output logic [Width-1:0]    o_data,
    output logic                o_last,
    input  logic                i_ready,
    output logic [CntWidth-1:0] o_beat_cnt
);

    localparam int PidxW = (PacketLen > 1) ? $clog2(PacketLen) : 1;
    localparam logic [PidxW-1:0] PidxLast = PidxW'(PacketLen - 1);

    logic [Width-1:0]    buf_q [3];
    logic [Width-1:0]    buf_d [3];
    logic [1:0]          head_q, head_d;
    logic [1:0]          tail_q, tail_d;
    logic [1:0]          occ_q, occ_d;
    logic                inflight_q, inflight_d;
    logic [PidxW-1:0]    pidx_q, pidx_d;
    logic [CntWidth-1:0] beat_cnt_q, beat_cnt_d;

    logic [2:0]          level;
    logic                xfer;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words already buffered plus the one arriving next edge; popping is allowed
    // only while this stays below 3, so the buffer can never overflow.
    always_comb begin
        level = {1'b0, occ_q} + {2'b00, inflight_q};
    end

    assign o_rd_en    = rst_n & i_enable & ~i_empty & (level < 3'd3);
    assign o_valid    = (occ_q != 2'd0);
    assign o_last     = o_valid & (pidx_q == PidxLast);
    assign xfer       = o_valid & i_ready;
    assign o_beat_cnt = beat_cnt_q;

    always_comb begin
        o_data = buf_q[0];
        case (head_q)
            2'd1:    o_data = buf_q[1];
            2'd2:    o_data = buf_q[2];
            default: o_data = buf_q[0];
        endcase
    end

    always_comb begin
        buf_d      = buf_q;
        head_d     = head_q;
        tail_d     = tail_q;
        pidx_d     = pidx_q;
        beat_cnt_d = beat_cnt_q;
        inflight_d = o_rd_en;

        if (inflight_q) begin
            for (int i = 0; i < 3; i++) begin
                if (tail_q == 2'(i)) begin
                    buf_d[i] = i_rd_data;
                end
            end
            tail_d = ptr_inc(tail_q);
        end

        if (xfer) begin
            head_d     = ptr_inc(head_q);
            beat_cnt_d = beat_cnt_q + CntWidth'(1);
            pidx_d     = (pidx_q == PidxLast) ? '0 : pidx_q + PidxW'(1);
        end

        occ_d = 2'(level - {2'b00, xfer});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            pidx_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            buf_q      <= buf_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            pidx_q     <= pidx_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side consumer for `async_fifo`, on the `clk_rd` domain. Pops words from the FIFO read port, absorbs the FIFO's one-cycle read latency in a 3-entry prefetch buffer, and presents them as a valid/ready stream. The stream is framed into fixed-length packets (`o_last`) and a running beat count is kept. Sustains one word per clock with no combinational path from `i_ready` to `o_rd_en`.

## Interface

Parameters:
- `Width`, 8: data width; must match the FIFO `Width`.
- `PacketLen`, 4: beats per packet, range 1..256.
- `CntWidth`, 16: width of `o_beat_cnt`.

Ports:
- `clk`  in  1  clock; connects to the FIFO `clk_rd`.
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `i_enable`  in  1  while high, new FIFO pops may be issued.
- `o_rd_en`  out  1  pop request to the FIFO `i_rd_en`.
- `i_rd_data`  in  Width  FIFO `o_rd_data`; valid one cycle after an accepted pop.
- `i_empty`  in  1  FIFO `o_empty`.
- `o_valid`  out  1  stream data valid.
- `o_data`  out  Width  stream data.
- `o_last`  out  1  the current beat is the final beat of a packet.
- `i_ready`  in  1  downstream accepts the current beat.
- `o_beat_cnt`  out  CntWidth  total beats transferred; wraps modulo 2^CntWidth.

## Operation

State:
- 3-entry buffer `buf[0..2]`.
- Head and tail pointers, 2 bits each, counting 0→1→2→0. Value 3 is never reached.
- Occupancy `occ`, range 0..3.
- `inflight` flag: a pop was issued last cycle.
- Packet beat index `pidx`, range 0..PacketLen-1.
- `o_beat_cnt` register.

Pop and capture:
- Pop rule (combinational from registers and inputs): `o_rd_en = rst_n & i_enable & ~i_empty & (occ + inflight < 3)`.
- `inflight` is set to `o_rd_en` on each clock edge.
- When `inflight` is high, `i_rd_data` is written to `buf[tail]` on that edge and `tail` advances, wrapping 2→0.

Output:
- `o_valid = (occ != 0)`.
- `o_data = buf[head]`.
- `o_last = o_valid & (pidx == PacketLen-1)`.

Transfer:
- A transfer occurs when `o_valid & i_ready`.
- On a transfer: `head` advances (wrapping), `o_beat_cnt` increments, and `pidx` increments or wraps to 0 after PacketLen-1.
- Occupancy update: `occ_next = occ + inflight - transfer`. A simultaneous capture and transfer leaves `occ` unchanged.

Enable and flow control:
- `i_enable` low blocks new pops only. In-flight data is still captured and buffered data still drains.
- `i_ready` low holds `o_data` and `o_last` stable while `o_valid` is high.

Never:
- Overflow: `occ + inflight` never exceeds 3.
- Read of an empty buffer: `o_valid` low whenever `occ` is 0.
- Pop while `i_empty` is high.

## Timing

- Reset values: `o_rd_en` 0, `o_valid` 0, `o_data` 0 (buffer cleared), `o_last` 0, `o_beat_cnt` 0, `pidx` 0, `occ` 0, `inflight` 0.
- Reset mid-operation: all state clears immediately. In-flight and buffered words are discarded.
- Latency, pop to stream:
  - Pop at edge N: data captured at edge N+1, `o_valid` high after N+1.
  - From `i_empty` falling to `o_valid` rising: 1 clock plus the pop cycle.
- Throughput: one beat per clock when `i_empty` stays low and `i_ready` stays high (steady state `occ` = 1, `inflight` = 1).
- Back-pressure: with `i_ready` low, pops stop once `occ + inflight` = 3. At most 3 words are held.
- Restart: when `i_ready` rises with `occ` = 3, the beats stream back-to-back. A new pop issues in the first cycle where `occ + inflight` < 3.
- PacketLen = 1: `o_last` is high on every valid beat.

## Test plan

- **Reset and empty FIFO.** Assert `rst_n` low for 2 clk, then hold `i_empty` = 1, `i_enable` = 1, `i_ready` = 1.
  - Required: `o_rd_en`, `o_valid`, `o_last` stay 0.
  - Required: `o_beat_cnt` = 0 and `o_data` = 0.
- **Streaming.** FIFO preloaded with 0x10..0x17, `i_ready` = 1.
  - Required: 8 consecutive beats 0x10..0x17, one per clock after the 2-cycle startup.
  - Required: `o_last` high on 0x13 and 0x17; `o_beat_cnt` ends at 8.
- **Back-pressure.** Hold `i_ready` = 0 while the FIFO is non-empty.
  - Required: exactly 3 pops, then `o_rd_en` stays 0; `o_data` holds the first word.
  - Then release `i_ready`: order is preserved, no duplicate or lost word across pointer wrap 2→0.
- **Enable gating.** Drop `i_enable` in the same cycle that `o_rd_en` is high.
  - Required: the in-flight word is still captured and delivered.
  - Required: no further pops until `i_enable` returns to 1.
- **Reset mid-packet.** Pulse `rst_n` low after 2 of 4 beats with `occ` = 2.
  - Required: outputs return to reset values.
  - Required: the next delivered beat has `pidx` 0 and `o_last` is first seen on the 4th beat after reset.
- **Count wrap.** Use `CntWidth` = 4 and deliver 17 beats.
  - Required: `o_beat_cnt` = 1.
  - Required: random `i_ready` / `i_empty` stimulus gives a scoreboard match against the FIFO write order.
